iter_rotate_shifter: RTL and testbench

- Multi-cycle shift/rotate unit that provides the right-logical and rotate operations the single-cycle SLL/SRA shifter does not.
- Sits beside the ALU in the execute stage for SRL/ROR/ROL opcodes.
- Shifts one bit position per clock, using a Start/Busy/Done handshake so the pipeline can stall until Done.
- Result is held stable until the next accepted Start.

---
 rtl/iter_rotate_shifter.sv | 72 +++++++
 tb/tb_iter_rotate_shifter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/iter_rotate_shifter.sv
// Multi-cycle SRL/ROR/ROL unit: moves the operand one bit per clock and
// signals completion with a one-cycle Done pulse; the result holds until the next Start.
module iter_rotate_shifter #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Shift_In,
  input  logic [SHAMT_W-1:0] Shift_Val,
  input  logic [1:0]         Mode,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Shift_Out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state;
  logic [SHAMT_W-1:0] count;
  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   shift_next;

  // Reserved mode 11 falls into the default arm and behaves as SRL.
  always_comb begin
    shift_next = {1'b0, Shift_Out[WIDTH-1:1]};
    case (mode_q)
      2'b01:   shift_next = {Shift_Out[0], Shift_Out[WIDTH-1:1]};
      2'b10:   shift_next = {Shift_Out[WIDTH-2:0], Shift_Out[WIDTH-1]};
      default: shift_next = {1'b0, Shift_Out[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      Shift_Out <= '0;
      count     <= '0;
      mode_q    <= 2'b00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            Shift_Out <= Shift_In;
            count     <= Shift_Val;
            mode_q    <= Mode;
            state     <= (Shift_Val == '0) ? DONE : SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          Shift_Out <= shift_next;
          count     <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state == SHIFT);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_iter_rotate_shifter.sv
// Scoreboard bench for iter_rotate_shifter: a driver pushes expected results and
// Done cycles computed by plain arithmetic; a negedge monitor pops and compares.
module tb_iter_rotate_shifter;

  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Start = 1'b0;
  logic [W-1:0]  Shift_In = '0;
  logic [SW-1:0] Shift_Val = '0;
  logic [1:0]    Mode = 2'b00;
  logic          Busy;
  logic          Done;
  logic [W-1:0]  Shift_Out;

  iter_rotate_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .Shift_In  (Shift_In),
    .Shift_Val (Shift_Val),
    .Mode      (Mode),
    .Busy      (Busy),
    .Done      (Done),
    .Shift_Out (Shift_Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] result;
    int           accept_cyc;
    int           done_cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_result = '0;
  bit           monitor_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: rotates are taken from a doubled operand, SRL is a plain shift.
  function automatic logic [W-1:0] ref_model(logic [W-1:0] x, int n, logic [1:0] m);
    logic [2*W-1:0] d;
    d = {x, x};
    case (m)
      2'b01: begin d = d >> n; return d[W-1:0]; end
      2'b10: begin d = d << n; return d[2*W-1:W]; end
      default: return x >> n;
    endcase
  endfunction

  function automatic bit model_busy();
    return sb.size() != 0 && cyc >= sb[0].accept_cyc && cyc < sb[0].done_cyc;
  endfunction

  task automatic checkOutput(string name, logic [W-1:0] actual, logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%h, expected 0x%h", name, cyc, actual, expected);
    end
  endtask

  // Called at a negedge; holds Start until the model says the unit is free.
  task automatic applyStimulus(logic [W-1:0] din, int n, logic [1:0] m);
    int waited;
    waited    = 0;
    Start     = 1'b1;
    Shift_In  = din;
    Shift_Val = SW'(n);
    Mode      = m;
    while (model_busy() && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got busy after %0d cycles, expected idle", waited);
    end else begin
      sb.push_back('{ref_model(din, n, m), cyc + 1, cyc + 1 + n});
    end
    @(negedge clk);
    Start     = 1'b0;
    Shift_In  = W'($urandom);
    Shift_Val = SW'($urandom);
    Mode      = 2'($urandom);
  endtask

  task automatic idle(int k);
    repeat (k) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    bit exp_done;
    if (monitor_on && !rst) begin
      exp_done = sb.size() != 0 && cyc == sb[0].done_cyc;
      checkOutput("busy", W'(Busy), W'(model_busy()));
      checkOutput("done", W'(Done), W'(exp_done));
      if (exp_done) begin
        checkOutput("result", Shift_Out, sb[0].result);
        last_result = sb[0].result;
        void'(sb.pop_front());
      end else if (sb.size() == 0 || cyc < sb[0].accept_cyc) begin
        checkOutput("hold", Shift_Out, last_result);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    rst = 1'b1;
    idle(2);
    checkOutput("reset_busy", W'(Busy), '0);
    checkOutput("reset_done", W'(Done), '0);
    checkOutput("reset_out", Shift_Out, '0);
    rst = 1'b0;
    idle(1);
    monitor_on = 1'b1;
    idle(2);

    applyStimulus(16'h8000, 15, 2'b00);
    idle(3);
    applyStimulus(16'h8001, 1, 2'b01);
    idle(1);
    applyStimulus(16'h1234, 4, 2'b10);
    idle(2);
    applyStimulus(16'hA5A5, 0, 2'b01);
    idle(2);
    applyStimulus(16'hF000, 4, 2'b11);
    idle(2);

    // Second request is held through the first op's Busy and taken in its Done cycle.
    applyStimulus(16'hFFFF, 6, 2'b00);
    applyStimulus(16'h0001, 3, 2'b10);
    idle(3);

    // Asynchronous reset in the middle of a long shift.
    applyStimulus(16'hFFFF, 8, 2'b00);
    idle(3);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", W'(Busy), '0);
    checkOutput("abort_done", W'(Done), '0);
    checkOutput("abort_out", Shift_Out, '0);
    sb.delete();
    last_result = '0;
    @(negedge clk);
    rst = 1'b0;
    idle(15);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(W'($urandom), int'($urandom_range(0, W - 1)), 2'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending results, expected 0", sb.size());
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
